// File: rtl/actideriv_pkg.sv
// Shared types and fixed-point constants for the hard-sigmoid activation/derivative pipeline.
package actideriv_pkg;

  typedef enum logic [1:0] {
    RegionInner = 2'd0,
    RegionOuter = 2'd1,
    RegionSat   = 2'd2
  } region_e;

  localparam logic MODE_BWD = 1'b0;
  localparam logic MODE_FWD = 1'b1;

  function automatic logic signed [63:0] fx_one(input int unsigned frac_w);
    return 64'sd1 <<< frac_w;
  endfunction

  function automatic logic signed [63:0] fx_half(input int unsigned frac_w);
    return 64'sd1 <<< (frac_w - 1);
  endfunction

  function automatic logic signed [63:0] fx_three(input int unsigned frac_w);
    return 64'sd3 <<< frac_w;
  endfunction

endpackage

// File: rtl/actideriv_lane.sv
// One lane: classify z into a sigmoid region (stage 1 input side) and compute the
// piecewise-linear result from the registered region/operand (stage 2 input side).
module actideriv_lane
  import actideriv_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned FRAC_W = 20
) (
  input  logic                     cls_mode_i,
  input  logic signed [DATA_W-1:0] cls_grad_i,
  input  logic signed [DATA_W-1:0] cls_z_i,
  output region_e                  cls_region_o,
  output logic signed [DATA_W-1:0] cls_operand_o,
  input  logic                     cmp_mode_i,
  input  region_e                  cmp_region_i,
  input  logic signed [DATA_W-1:0] cmp_operand_i,
  output logic signed [DATA_W-1:0] cmp_result_o
);

  localparam logic signed [DATA_W-1:0] One    = DATA_W'(fx_one(FRAC_W));
  localparam logic signed [DATA_W-1:0] Half   = DATA_W'(fx_half(FRAC_W));
  localparam logic signed [DATA_W-1:0] Three  = DATA_W'(fx_three(FRAC_W));
  localparam logic signed [DATA_W-1:0] Five8  = DATA_W'((64'sd5 <<< FRAC_W) >>> 3);
  localparam logic signed [DATA_W-1:0] Three8 = DATA_W'(fx_three(FRAC_W) >>> 3);

  logic                     op_neg;
  logic signed [DATA_W-1:0] op_sh2;
  logic signed [DATA_W-1:0] op_sh3;

  always_comb begin
    if (cls_z_i < -Three || cls_z_i > Three) begin
      cls_region_o = RegionSat;
    end else if (cls_z_i < -One || cls_z_i > One) begin
      cls_region_o = RegionOuter;
    end else begin
      cls_region_o = RegionInner;
    end
    // Forward mode only needs z; backprop only needs grad (region already captured).
    cls_operand_o = (cls_mode_i == MODE_FWD) ? cls_z_i : cls_grad_i;
  end

  assign op_neg = cmp_operand_i[DATA_W-1];
  assign op_sh2 = cmp_operand_i >>> 2;
  assign op_sh3 = cmp_operand_i >>> 3;

  always_comb begin
    cmp_result_o = '0;
    if (cmp_mode_i == MODE_BWD) begin
      case (cmp_region_i)
        RegionInner: cmp_result_o = op_sh2;
        RegionOuter: cmp_result_o = op_sh3;
        default:     cmp_result_o = '0;
      endcase
    end else begin
      case (cmp_region_i)
        RegionInner: cmp_result_o = Half + op_sh2;
        RegionOuter: cmp_result_o = op_neg ? (Three8 + op_sh3) : (Five8 + op_sh3);
        RegionSat:   cmp_result_o = op_neg ? '0 : One;
        default:     cmp_result_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/actideriv_pipe.sv
// Two-stage valid/ready pipeline of LANES hard-sigmoid lanes (activation or derivative).
// Define SAT_CNT_EN to build the saturated-sample counter; otherwise sat_cnt_o is tied to 0.
module actideriv_pipe
  import actideriv_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned FRAC_W = 20,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      in_mode_i,
  input  logic [LANES*DATA_W-1:0]   in_grad_i,
  input  logic [LANES*DATA_W-1:0]   in_z_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LANES*DATA_W-1:0]   out_data_o,
  output logic                      out_mode_o,
  input  logic                      sat_clr_i,
  output logic [CNT_W-1:0]          sat_cnt_o
);

  region_e                  cls_region  [LANES];
  logic signed [DATA_W-1:0] cls_op      [LANES];
  region_e                  s1_region_q [LANES];
  logic signed [DATA_W-1:0] s1_op_q     [LANES];
  logic                     s1_valid_q, s1_mode_q;
  logic                     s2_valid_q, s2_mode_q;
  logic [LANES*DATA_W-1:0]  s2_data_q;
  logic [LANES*DATA_W-1:0]  cmp_result;
  logic                     in_fire, s2_load, out_fire;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    actideriv_lane #(
      .DATA_W(DATA_W),
      .FRAC_W(FRAC_W)
    ) u_lane (
      .cls_mode_i   (in_mode_i),
      .cls_grad_i   (in_grad_i[g*DATA_W +: DATA_W]),
      .cls_z_i      (in_z_i[g*DATA_W +: DATA_W]),
      .cls_region_o (cls_region[g]),
      .cls_operand_o(cls_op[g]),
      .cmp_mode_i   (s1_mode_q),
      .cmp_region_i (s1_region_q[g]),
      .cmp_operand_i(s1_op_q[g]),
      .cmp_result_o (cmp_result[g*DATA_W +: DATA_W])
    );
  end

  // A stage loads when empty or when its occupant leaves in the same cycle.
  assign out_fire    = s2_valid_q && out_ready_i;
  assign s2_load     = s1_valid_q && (!s2_valid_q || out_ready_i);
  assign in_ready_o  = !s1_valid_q || s2_load;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_valid_o = s2_valid_q;
  assign out_data_o  = s2_data_q;
  assign out_mode_o  = s2_mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_data_q  <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_region_q[i] <= RegionInner;
        s1_op_q[i]     <= '0;
      end
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_mode_q  <= in_mode_i;
        for (int i = 0; i < LANES; i++) begin
          s1_region_q[i] <= cls_region[i];
          s1_op_q[i]     <= cls_op[i];
        end
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_load) begin
        s2_valid_q <= 1'b1;
        s2_mode_q  <= s1_mode_q;
        s2_data_q  <= cmp_result;
      end else if (out_fire) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

`ifdef SAT_CNT_EN
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic [CNT_W:0]   sat_lanes, sat_sum;

  always_comb begin
    sat_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cls_region[i] == RegionSat) sat_lanes = sat_lanes + (CNT_W+1)'(1);
    end
    sat_sum   = {1'b0, sat_cnt_q} + sat_lanes;
    sat_cnt_d = sat_cnt_q;
    if (sat_clr_i) begin
      sat_cnt_d = '0;
    end else if (in_fire) begin
      sat_cnt_d = sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt_o = sat_cnt_q;
`else
  logic unused_sat_clr;
  assign unused_sat_clr = sat_clr_i;
  assign sat_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_actideriv_pipe.sv
// Directed bench for actideriv_pipe: vector table plus backpressure, reset and counter sequences.
module tb_actideriv_pipe;

  localparam int unsigned DW = 24;
  localparam int unsigned FW = 20;
  localparam int unsigned LN = 4;
  localparam int unsigned CW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_mode;
  logic [LN*DW-1:0]  in_grad, in_z, out_data;
  logic              out_valid, out_ready, out_mode, sat_clr;
  logic [CW-1:0]     sat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  actideriv_pipe #(
    .DATA_W(DW),
    .FRAC_W(FW),
    .LANES (LN),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_mode_i  (in_mode),
    .in_grad_i  (in_grad),
    .in_z_i     (in_z),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_mode_o (out_mode),
    .sat_clr_i  (sat_clr),
    .sat_cnt_o  (sat_cnt)
  );

`ifdef SAT_CNT_EN
  logic             sm_valid, sm_ready, sm_out_valid, sm_out_mode;
  logic [LN*DW-1:0] sm_out_data;
  logic [2:0]       sm_cnt;

  actideriv_pipe #(
    .DATA_W(DW),
    .FRAC_W(FW),
    .LANES (LN),
    .CNT_W (3)
  ) dut_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (sm_valid),
    .in_ready_o (sm_ready),
    .in_mode_i  (in_mode),
    .in_grad_i  (in_grad),
    .in_z_i     (in_z),
    .out_valid_o(sm_out_valid),
    .out_ready_i(1'b1),
    .out_data_o (sm_out_data),
    .out_mode_o (sm_out_mode),
    .sat_clr_i  (1'b0),
    .sat_cnt_o  (sm_cnt)
  );
`endif

  typedef struct {
    logic        mode;
    logic [23:0] grad;
    logic [23:0] z;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1; returns once the beat has been accepted.
  task automatic send_beat(input logic mode, input logic [95:0] g, input logic [95:0] z);
    bit ok;
    in_mode  = mode;
    in_grad  = g;
    in_z     = z;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept timeout", 96'(ok), 96'(1));
  endtask

  function automatic logic [95:0] four(input logic [23:0] v);
    return {v, v, v, v};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [95:0] g, z, exp_d, held_d;
    logic [23:0] bp_z   [6];
    logic [23:0] bp_exp [6];
    int          lat, sent, rcv;
    bit          held_v;

    vecs[0]  = '{1'b0, 24'h100000, 24'h080000, 24'h040000};
    vecs[1]  = '{1'b0, 24'h100000, 24'h100000, 24'h040000};
    vecs[2]  = '{1'b0, 24'h100000, 24'h180000, 24'h020000};
    vecs[3]  = '{1'b0, 24'h100000, 24'h300000, 24'h020000};
    vecs[4]  = '{1'b0, 24'h100000, 24'h300001, 24'h000000};
    vecs[5]  = '{1'b0, 24'h100000, 24'hC00000, 24'h000000};
    vecs[6]  = '{1'b0, 24'h100000, 24'hF00000, 24'h040000};
    vecs[7]  = '{1'b0, 24'h100000, 24'hD00000, 24'h020000};
    vecs[8]  = '{1'b0, 24'hF00000, 24'h000000, 24'hFC0000};
    vecs[9]  = '{1'b0, 24'hF00000, 24'hE80000, 24'hFE0000};
    vecs[10] = '{1'b1, 24'h123456, 24'h000000, 24'h080000};
    vecs[11] = '{1'b1, 24'h123456, 24'h200000, 24'h0E0000};
    vecs[12] = '{1'b1, 24'h000000, 24'hE00000, 24'h020000};
    vecs[13] = '{1'b1, 24'h000000, 24'h400000, 24'h100000};
    vecs[14] = '{1'b1, 24'h000000, 24'hC00000, 24'h000000};
    vecs[15] = '{1'b1, 24'h000000, 24'h100000, 24'h0C0000};
    vecs[16] = '{1'b1, 24'h000000, 24'hF00000, 24'h040000};
    vecs[17] = '{1'b1, 24'h000000, 24'hD00000, 24'h000000};
    vecs[18] = '{1'b1, 24'h000000, 24'hCFFFFF, 24'h000000};

    bp_z   = '{24'h000000, 24'h040000, 24'h080000, 24'h0C0000, 24'h100000, 24'h140000};
    bp_exp = '{24'h080000, 24'h090000, 24'h0A0000, 24'h0B0000, 24'h0C0000, 24'h0C8000};

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_grad = '0; in_z = '0;
    out_ready = 1'b1; sat_clr = 1'b0;
`ifdef SAT_CNT_EN
    sm_valid = 1'b0;
`endif
    #1;
    chk("reset out_valid", 96'(out_valid), 96'(0));
    chk("reset out_data", out_data, 96'(0));
    chk("reset out_mode", 96'(out_mode), 96'(0));
    chk("reset sat_cnt", 96'(sat_cnt), 96'(0));
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset in_ready", 96'(in_ready), 96'(1));

    // Table: each vector on one lane, idle lanes carry z=0, grad=0.
    for (int k = 0; k < 19; k++) begin
      g = '0;
      z = '0;
      exp_d = four(vecs[k].mode ? 24'h080000 : 24'h000000);
      g[(k % LN)*DW +: DW]     = vecs[k].grad;
      z[(k % LN)*DW +: DW]     = vecs[k].z;
      exp_d[(k % LN)*DW +: DW] = vecs[k].exp;
      send_beat(vecs[k].mode, g, z);
      lat = 0;
      while (!out_valid && lat < 8) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("vec%0d latency", k), 96'(lat), 96'(1));
      chk($sformatf("vec%0d data", k), out_data, exp_d);
      chk($sformatf("vec%0d mode", k), 96'(out_mode), 96'(vecs[k].mode));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d no repeat", k), 96'(out_valid), 96'(0));
    end

    // Backpressure: 6 beats offered back-to-back, out_ready held low for 5 cycles.
    sent = 0;
    rcv = 0;
    held_v = 1'b0;
    held_d = '0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        in_mode = 1'b1;
        in_grad = '0;
        in_z    = four(bp_z[sent]);
      end
      #1;
      if (held_v) chk($sformatf("bp hold cyc%0d", cyc), out_data, held_d);
      if (cyc == 3) begin
        chk("bp full in_ready", 96'(in_ready), 96'(0));
        chk("bp accepted before full", 96'(sent), 96'(2));
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp beat%0d", rcv), out_data, four(bp_exp[rcv]));
        rcv++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp received", 96'(rcv), 96'(6));
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp drained", 96'(out_valid), 96'(0));
    end

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send_beat(1'b1, '0, four(24'h200000));
    send_beat(1'b1, '0, four(24'hE00000));
    chk("inflight out_valid", 96'(out_valid), 96'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 96'(out_valid), 96'(0));
    chk("async reset out_data", out_data, 96'(0));
    chk("async reset in_ready", 96'(in_ready), 96'(1));
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post reset idle %0d", i), 96'(out_valid), 96'(0));
    end

    // Saturation counter: beats with 2, 4 and 0 SAT lanes, then clear with a 1-SAT beat.
    send_beat(1'b0, four(24'h100000), {24'h0, 24'h0, 24'h400000, 24'hC00000});
    send_beat(1'b1, '0, {24'h300001, 24'hCFFFFF, 24'h400000, 24'hC00000});
    send_beat(1'b0, four(24'h100000), {24'h300000, 24'hD00000, 24'h0, 24'h100000});
`ifdef SAT_CNT_EN
    chk("sat_cnt sum", 96'(sat_cnt), 96'(6));
`else
    chk("sat_cnt tied", 96'(sat_cnt), 96'(0));
`endif
    sat_clr = 1'b1;
    send_beat(1'b0, four(24'h100000), {24'h0, 24'h0, 24'h0, 24'h400000});
    sat_clr = 1'b0;
    chk("sat_cnt clear", 96'(sat_cnt), 96'(0));
    send_beat(1'b1, '0, {24'h0, 24'h0, 24'h0, 24'h400000});
`ifdef SAT_CNT_EN
    chk("sat_cnt after clear", 96'(sat_cnt), 96'(1));
    // Narrow counter instance: 4 + 4 clips at 7 and stays there.
    in_mode = 1'b1;
    in_grad = '0;
    in_z = four(24'h400000);
    sm_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("small cnt 4", 96'(sm_cnt), 96'(4));
    @(posedge clk);
    #1;
    chk("small cnt clip", 96'(sm_cnt), 96'(7));
    @(posedge clk);
    #1;
    chk("small cnt hold", 96'(sm_cnt), 96'(7));
    sm_valid = 1'b0;
`else
    chk("sat_cnt after clear", 96'(sat_cnt), 96'(0));
`endif
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/actideriv_pipe.md
Name: actideriv_pipe

Overview:
Pipelined, multi-lane, parametrised successor to the combinational hard-sigmoid derivative unit. Per lane, mode 0 (backprop) computes grad*sigma'(z) and mode 1 (forward) computes sigma(z). Both use the same 3-region piecewise-linear sigmoid. The block sits between the layer accumulator and the weight-update / next-layer datapath, with valid/ready handshakes on both sides.

Parameters:
DATA_W, 24, signed two's-complement sample width; constraint DATA_W-FRAC_W >= 3
FRAC_W, 20, fractional bits (1.0 = 1<<FRAC_W)
LANES, 4, parallel channels per beat
CNT_W, 32, saturation counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_mode  in  1  0 = backprop derivative, 1 = forward activation
in_grad  in  LANES*DATA_W  per-lane upstream gradient (ignored in mode 1); lane i at [i*DATA_W +: DATA_W]
in_z  in  LANES*DATA_W  per-lane pre-activation z
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  LANES*DATA_W  per-lane result
out_mode  out  1  mode tag travelling with the beat
sat_clr  in  1  synchronous clear of sat_cnt
sat_cnt  out  CNT_W  count of saturated lane-samples

Behaviour:
- Reset: out_valid=0, both stage-valid flags=0, sat_cnt=0, out_data=0, out_mode=0. in_ready=1 after reset. Asserting reset mid-operation flushes all beats in flight; nothing is replayed.
- Region classification uses signed compares against ONE=1<<FRAC_W and THREE=3<<FRAC_W:
  - SAT: z<-THREE or z>THREE
  - OUTER: not SAT, and z<-ONE or z>ONE
  - INNER: otherwise
  - z exactly ±1.0 is INNER; z exactly ±3.0 is OUTER.
- Mode 0 results: SAT -> 0; OUTER -> grad>>>3; INNER -> grad>>>2. Shifts are arithmetic, truncating toward -inf.
- Mode 1 results:
  - z<-THREE -> 0; z>THREE -> ONE.
  - INNER -> HALF+(z>>>2).
  - OUTER, z>0 -> 5/8+(z>>>3); OUTER, z<0 -> 3/8+(z>>>3).
  - Constants are fixed-point (5<<FRAC_W)>>3 and (3<<FRAC_W)>>3.
  - Result is always in [0, ONE], so no overflow is possible.
- Pipeline: 2 register stages.
  - S1 registers region code, the selected operand and mode.
  - S2 registers the shifted/added result, which drives out_data.
  - Latency is 2 cycles from input handshake to out_valid when unstalled. Throughput is 1 beat/cycle.
- Handshake:
  - A beat transfers on valid&&ready at either side.
  - Each stage loads when it is empty or when its content moves on in the same cycle.
  - in_ready = !s1_valid || s2 advancing.
  - out_data/out_mode are held stable while out_valid && !out_ready.
  - in_valid may drop without waiting for ready. No combinational path from in_valid to out_valid.
- Full: with out_ready low, the block absorbs 2 beats and then deasserts in_ready. No beat is lost, duplicated or reordered.
- Simultaneous accept and emit in the same cycle is supported at full rate.

Optional Feature:
SAT_CNT_EN.
- Defined: on each accepted input beat, sat_cnt += number of lanes classified SAT (either mode).
  - Counter saturates at all-ones and never wraps.
  - sat_clr has priority over an increment in the same cycle; the result after that cycle is 0.
- Undefined: sat_cnt is tied to 0 and sat_clr is ignored; no counter logic is built.

Decomposition:
- Package actideriv_pkg holds:
  - region enum (INNER, OUTER, SAT)
  - mode constants (MODE_BWD=0, MODE_FWD=1)
  - functions returning ONE/HALF/THREE for a given FRAC_W
- Sub-module actideriv_lane, instantiated LANES times in a generate loop:
  - purely combinational classify + compute
  - parametrised by DATA_W and FRAC_W
- The pipeline registers and handshake control stay in actideriv_pipe.

Test Plan:
(All values: DATA_W=24, FRAC_W=20.)
1. Mode 0 region sweep, grad=0x100000:
   - z=0x080000 -> 0x040000
   - z=0x100000 -> 0x040000
   - z=0x180000 -> 0x020000
   - z=0x300000 -> 0x020000
   - z=0x300001 -> 0x000000
   - z=0xC00000 (-4.0) -> 0x000000
2. Mode 0, negative gradient: grad=0xF00000 (-1.0).
   - z=0 -> 0xFC0000
   - z=0xE80000 (-1.5) -> 0xFE0000
3. Mode 1:
   - z=0 -> 0x080000
   - z=0x200000 -> 0x0E0000
   - z=0xE00000 -> 0x020000
   - z=0x400000 -> 0x100000
   - z=0xC00000 -> 0x000000
   - out_mode=1 on each of these beats.
4. Backpressure: stream 6 beats back-to-back with out_ready=0 for 5 cycles, then 1.
   - in_ready falls after 2 beats accepted.
   - All 6 results arrive in order, each exactly once; out_data stays stable while stalled.
5. Reset mid-stream: drop rst_n with 2 beats in flight.
   - out_valid=0 immediately (asynchronous).
   - No stale beat appears after release.
6. SAT_CNT_EN defined:
   - 3 beats with 2, 4 and 0 saturated lanes -> sat_cnt=6.
   - sat_clr asserted together with a 1-saturated-lane beat -> sat_cnt=0.
   - Preload near max -> sat_cnt holds at 0xFFFFFFFF.
